// File: rtl/lcd_bus_writer.sv
// HD44780 write-only bus driver: buffers {rs, byte} entries in a small FIFO and
// replays each one with setup / enable-pulse / hold / execution-wait timing.
module lcd_bus_writer #(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_CYC       = 11,
    parameter int unsigned HOLD_CYC     = 1,
    parameter int unsigned WAIT_CYC     = 1000,
    parameter int unsigned CLR_WAIT_CYC = 36000,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       rs,
    output logic       rw,
    output logic       en,
    output logic [7:0] dout
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic             en_q, en_d;
    logic [7:0]       dout_q, dout_d;
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [8:0]       mem_q [DEPTH];

    logic             full, empty, push, pop, long_wait;
    logic [8:0]       head;

    // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push  = wr_valid && !full;
    assign head  = mem_q[rd_ptr_q[PW-1:0]];

    // Clear display (0x01) and return home (0x02/0x03) need the long wait.
    assign long_wait = !rs_q && ((dout_q[7:1] == 7'b0000000 && dout_q[0]) ||
                                 (dout_q[7:1] == 7'b0000001));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        dout_d   = dout_q;
        en_d     = en_q;
        pop      = 1'b0;
        wr_ptr_d = push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;

        case (state_q)
            ST_IDLE: begin
                en_d = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    rs_d    = head[8];
                    dout_d  = head[7:0];
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                en_d = 1'b0;
                if (cnt_q == '0) begin
                    en_d    = 1'b1;
                    cnt_d   = CNT_W'(EN_CYC - 1);
                    state_d = ST_PULSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                en_d = 1'b1;
                if (cnt_q == '0) begin
                    en_d    = 1'b0;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                en_d = 1'b0;
                if (cnt_q == '0) begin
                    cnt_d   = long_wait ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(WAIT_CYC - 1);
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                en_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        rd_ptr_d = pop ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            en_q     <= 1'b0;
            dout_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            en_q     <= en_d;
            dout_q   <= dout_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= {wr_rs, wr_data};
        end
    end

    assign wr_ready = !full;
    assign busy     = (state_q != ST_IDLE) || !empty;
    assign rs       = rs_q;
    assign rw       = 1'b0;
    assign en       = en_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed self-checking bench for lcd_bus_writer with shortened timing parameters.
module tb_lcd_bus_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, busy, rs, rw, en;
    logic [7:0] dout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         rise_q[$];
    logic [7:0] dout_rec[$];
    logic       rs_rec[$];
    int         en_len = 0;
    logic       en_prev = 1'b0;

    lcd_bus_writer #(
        .SETUP_CYC   (2),
        .EN_CYC      (3),
        .HOLD_CYC    (1),
        .WAIT_CYC    (5),
        .CLR_WAIT_CYC(20),
        .DEPTH       (4),
        .CNT_W       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_valid(wr_valid),
        .wr_rs   (wr_rs),
        .wr_data (wr_data),
        .wr_ready(wr_ready),
        .busy    (busy),
        .rs      (rs),
        .rw      (rw),
        .en      (en),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Records each enable pulse (edge number, bus value) and checks its width.
    always @(negedge clk) begin
        if (!rst) begin
            en_len  = 0;
            en_prev = 1'b0;
        end else begin
            if (en && !en_prev) begin
                rise_q.push_back(cyc);
                dout_rec.push_back(dout);
                rs_rec.push_back(rs);
            end
            if (en) begin
                en_len++;
            end else if (en_prev) begin
                n_checks++;
                if (en_len !== 3) begin
                    n_fail++;
                    $display("FAIL en_width: got %0d cycles, expected 3", en_len);
                end
                en_len = 0;
            end
            en_prev = en;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        rise_q.delete();
        dout_rec.delete();
        rs_rec.delete();
    endtask

    // Holds wr_valid until the byte is taken; k is the accepting edge number.
    task automatic push(input logic r, input logic [7:0] d, output int k);
        int guard;
        guard    = 0;
        wr_rs    = r;
        wr_data  = d;
        wr_valid = 1'b1;
        while (!wr_ready && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: wr_ready stayed 0, expected 1");
        end
        step();
        k = cyc;
    endtask

    task automatic wait_idle(input int limit);
        int guard;
        guard = 0;
        while (busy && guard < limit) begin
            step();
            guard++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h55;
        repeat (4) step();
        n_checks += 6;
        if (en !== 1'b0)       begin n_fail++; $display("FAIL rst_en: got %b, expected 0", en); end
        if (rs !== 1'b0)       begin n_fail++; $display("FAIL rst_rs: got %b, expected 0", rs); end
        if (rw !== 1'b0)       begin n_fail++; $display("FAIL rst_rw: got %b, expected 0", rw); end
        if (dout !== 8'h00)    begin n_fail++; $display("FAIL rst_dout: got %h, expected 00", dout); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, expected 1", wr_ready); end
        wr_valid = 1'b0;
        step();
        rst = 1'b1;
        clear_rec();
        repeat (20) step();
        n_checks += 2;
        if (rise_q.size() !== 0) begin n_fail++; $display("FAIL rst_no_emit: got %0d pulses, expected 0", rise_q.size()); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_post_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_single();
        int   k;
        logic exp_en, exp_busy;
        clear_rec();
        push(1'b1, 8'h41, k);
        wr_valid = 1'b0;
        n_checks += 2;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_k: got %b, expected 1", busy); end
        if (en !== 1'b0)   begin n_fail++; $display("FAIL single_en_k: got %b, expected 0", en); end
        for (int e = k + 1; e <= k + 14; e++) begin
            step();
            exp_en   = (e >= k + 3) && (e <= k + 5);
            exp_busy = (e < k + 12);
            n_checks += 2;
            if (en !== exp_en) begin
                n_fail++;
                $display("FAIL single_en@k+%0d: got %b, expected %b", e - k, en, exp_en);
            end
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL single_busy@k+%0d: got %b, expected %b", e - k, busy, exp_busy);
            end
            if (e == k + 1) begin
                n_checks += 2;
                if (rs !== 1'b1)    begin n_fail++; $display("FAIL single_rs: got %b, expected 1", rs); end
                if (dout !== 8'h41) begin n_fail++; $display("FAIL single_dout: got %h, expected 41", dout); end
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0] cmds [4];
        int         gaps [4];
        int         k, k2;
        cmds = '{8'h01, 8'h02, 8'h03, 8'h38};
        gaps = '{27, 27, 27, 12};
        for (int i = 0; i < 4; i++) begin
            clear_rec();
            push(1'b0, cmds[i], k);
            push(1'b1, 8'h48, k2);
            wr_valid = 1'b0;
            wait_idle(200);
            n_checks++;
            if (rise_q.size() !== 2) begin
                n_fail++;
                $display("FAIL clr_count[%h]: got %0d pulses, expected 2", cmds[i], rise_q.size());
            end else begin
                n_checks += 5;
                if (rise_q[0] !== k + 3) begin
                    n_fail++; $display("FAIL clr_first_rise[%h]: got k+%0d, expected k+3", cmds[i], rise_q[0] - k);
                end
                if (rise_q[1] - rise_q[0] !== gaps[i]) begin
                    n_fail++; $display("FAIL clr_spacing[%h]: got %0d, expected %0d", cmds[i], rise_q[1] - rise_q[0], gaps[i]);
                end
                if (dout_rec[0] !== cmds[i] || rs_rec[0] !== 1'b0) begin
                    n_fail++; $display("FAIL clr_first_byte[%h]: got rs=%b %h, expected rs=0 %h", cmds[i], rs_rec[0], dout_rec[0], cmds[i]);
                end
                if (dout_rec[1] !== 8'h48) begin
                    n_fail++; $display("FAIL clr_second_dout[%h]: got %h, expected 48", cmds[i], dout_rec[1]);
                end
                if (rs_rec[1] !== 1'b1) begin
                    n_fail++; $display("FAIL clr_second_rs[%h]: got %b, expected 1", cmds[i], rs_rec[1]);
                end
            end
        end
    endtask

    task automatic test_full();
        int k;
        clear_rec();
        for (int i = 0; i < 6; i++) begin
            push(1'b1, 8'h10 + 8'(i), k);
            if (i == 4) begin
                n_checks++;
                if (wr_ready !== 1'b0) begin
                    n_fail++; $display("FAIL full_ready: got %b, expected 0", wr_ready);
                end
            end
        end
        wr_valid = 1'b0;
        wait_idle(400);
        n_checks++;
        if (rise_q.size() !== 6) begin
            n_fail++; $display("FAIL full_count: got %0d pulses, expected 6", rise_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (dout_rec[i] !== 8'h10 + 8'(i)) begin
                    n_fail++; $display("FAIL full_order[%0d]: got %h, expected %h", i, dout_rec[i], 8'h10 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_wrap();
        int k;
        clear_rec();
        for (int i = 0; i < 10; i++) begin
            push(1'b1, 8'h60 + 8'(3 * i), k);
            wr_valid = 1'b0;
            repeat ($urandom_range(0, 3)) step();
        end
        wait_idle(600);
        n_checks++;
        if (rise_q.size() !== 10) begin
            n_fail++; $display("FAIL wrap_count: got %0d pulses, expected 10", rise_q.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (dout_rec[i] !== 8'h60 + 8'(3 * i)) begin
                    n_fail++; $display("FAIL wrap_order[%0d]: got %h, expected %h", i, dout_rec[i], 8'h60 + 8'(3 * i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, guard;
        push(1'b1, 8'h70, k);
        push(1'b1, 8'h71, k);
        push(1'b1, 8'h72, k);
        wr_valid = 1'b0;
        guard = 0;
        while (!en && guard < 50) begin
            step();
            guard++;
        end
        n_checks++;
        if (en !== 1'b1) begin
            n_fail++; $display("FAIL mid_en_seen: got %b, expected 1", en);
        end
        rst = 1'b0;
        #1;
        n_checks += 4;
        if (en !== 1'b0)       begin n_fail++; $display("FAIL mid_en_drop: got %b, expected 0", en); end
        if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy: got %b, expected 0", busy); end
        if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b, expected 1", wr_ready); end
        if (dout !== 8'h00)    begin n_fail++; $display("FAIL mid_dout: got %h, expected 00", dout); end
        repeat (2) step();
        clear_rec();
        rst = 1'b1;
        repeat (40) step();
        n_checks += 2;
        if (rise_q.size() !== 0) begin n_fail++; $display("FAIL mid_no_emit: got %0d pulses, expected 0", rise_q.size()); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_post_busy: got %b, expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clear();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
